pipe_interlock: RTL and testbench

PIPE_INTERLOCK -- requirements
Module: pipe_interlock

---
 rtl/pipe_interlock_if.sv | 44 ++++
 rtl/pipe_interlock.sv | 148 ++++++++++++++
 tb/tb_pipe_interlock.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_interlock_if.sv
// Hazard/interlock bundle between the pipeline datapath and the interlock unit.
// The pipeline (master) drives stage sources, destinations and busy flags;
// the interlock (slave) returns forward selects, stalls, flushes and divider status.
interface pipe_interlock_if #(
  parameter int RW    = 5,
  parameter int CNT_W = 32
);
  logic [RW-1:0]    rsD, rtD;
  logic             branchD, jumpD;
  logic [RW-1:0]    rsE, rtE, writeregE;
  logic             regwriteE, memtoregE, div_startE;
  logic [RW-1:0]    writeregM;
  logic             regwriteM, memtoregM, exceptM;
  logic [RW-1:0]    writeregW;
  logic             regwriteW;
  logic             imem_busy, dmem_busy;
  logic [1:0]       forwardaD, forwardbD, forwardaE, forwardbE;
  logic             stallF, stallD, stallE, stallM, stallW;
  logic             flushF, flushD, flushE, flushM, flushW;
  logic             div_busyE, div_doneE;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output rsD, rtD, branchD, jumpD,
    output rsE, rtE, writeregE, regwriteE, memtoregE, div_startE,
    output writeregM, regwriteM, memtoregM, exceptM,
    output writeregW, regwriteW, imem_busy, dmem_busy,
    input  forwardaD, forwardbD, forwardaE, forwardbE,
    input  stallF, stallD, stallE, stallM, stallW,
    input  flushF, flushD, flushE, flushM, flushW,
    input  div_busyE, div_doneE, stall_cycles
  );

  modport slave (
    input  rsD, rtD, branchD, jumpD,
    input  rsE, rtE, writeregE, regwriteE, memtoregE, div_startE,
    input  writeregM, regwriteM, memtoregM, exceptM,
    input  writeregW, regwriteW, imem_busy, dmem_busy,
    output forwardaD, forwardbD, forwardaE, forwardbE,
    output stallF, stallD, stallE, stallM, stallW,
    output flushF, flushD, flushE, flushM, flushW,
    output div_busyE, div_doneE, stall_cycles
  );
endinterface

// File: rtl/pipe_interlock.sv
// Pipeline interlock: forwarding selects, load-use/branch hazard stalls,
// multi-cycle divider sequencing, stall/flush priority and a saturating
// stall-cycle counter.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no divide in flight; a div_startE launches one
// BUSY  | divide running; cnt counts down, cnt==0 is the done cycle
module pipe_interlock #(
  parameter int RW         = 5,
  parameter int DIV_CYCLES = 32,
  parameter int FWD_W2D    = 1,
  parameter int CNT_W      = 32
) (
  input logic            clk,
  input logic            resetn,
  pipe_interlock_if.slave bus
);

  localparam int CW = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(DIV_CYCLES - 2);

  typedef enum logic {IDLE, BUSY} div_state_t;

  div_state_t       state;
  logic [CW-1:0]    cnt;
  logic [CNT_W-1:0] stall_cnt;

  logic lwstall, brstall, div_stall, div_done;
  logic stall_m, stall_e, stall_d, stall_f;

  // Register 0 is hardwired, so it never produces a dependency.
  function automatic logic hit(input logic [RW-1:0] src, input logic [RW-1:0] dst,
                               input logic we);
    return we && (src != '0) && (src == dst);
  endfunction

  function automatic logic [1:0] fwd_d(input logic [RW-1:0] src);
    if (hit(src, bus.writeregE, bus.regwriteE))                     return 2'b01;
    else if (hit(src, bus.writeregM, bus.regwriteM))                return 2'b10;
    else if ((FWD_W2D != 0) && hit(src, bus.writeregW, bus.regwriteW)) return 2'b11;
    else                                                            return 2'b00;
  endfunction

  function automatic logic [1:0] fwd_e(input logic [RW-1:0] src);
    if (hit(src, bus.writeregM, bus.regwriteM))      return 2'b10;
    else if (hit(src, bus.writeregW, bus.regwriteW)) return 2'b01;
    else                                             return 2'b00;
  endfunction

  // Forward selects for decode-stage branch compare and execute-stage ALU.
  always_comb begin
    bus.forwardaD = fwd_d(bus.rsD);
    bus.forwardbD = fwd_d(bus.rtD);
    bus.forwardaE = fwd_e(bus.rsE);
    bus.forwardbE = fwd_e(bus.rtE);
  end

  // Load-use and branch-operand hazards detected in decode.
  always_comb begin
    lwstall = bus.memtoregE && (bus.writeregE != '0) &&
              ((bus.writeregE == bus.rsD) || (bus.writeregE == bus.rtD));
    brstall = (bus.branchD || bus.jumpD) &&
              (hit(bus.rsD, bus.writeregE, bus.regwriteE) ||
               hit(bus.rtD, bus.writeregE, bus.regwriteE) ||
               hit(bus.rsD, bus.writeregM, bus.memtoregM) ||
               hit(bus.rtD, bus.writeregM, bus.memtoregM));
  end

  // Divider stall/done decode; an exception or reset suppresses both.
  always_comb begin
    div_stall = 1'b0;
    div_done  = 1'b0;
    if (resetn && !bus.exceptM) begin
      if (state == IDLE) begin
        div_stall = bus.div_startE;
      end else begin
        div_stall = (cnt != '0);
        div_done  = (cnt == '0) && !bus.dmem_busy;
      end
    end
  end

  // Stall chain (downstream stalls propagate upstream) and flush generation.
  always_comb begin
    stall_m = bus.dmem_busy && !bus.exceptM;
    stall_e = stall_m || div_stall;
    stall_d = (stall_e || lwstall || brstall) && !bus.exceptM;
    stall_f = (stall_d || bus.imem_busy) && !bus.exceptM;

    bus.stallW = 1'b0;
    bus.stallM = stall_m;
    bus.stallE = stall_e;
    bus.stallD = stall_d;
    bus.stallF = stall_f;

    bus.flushW = bus.dmem_busy && !bus.exceptM;
    bus.flushM = bus.exceptM;
    bus.flushE = bus.exceptM || ((lwstall || brstall) && !stall_e);
    bus.flushD = bus.exceptM || (bus.imem_busy && !stall_d);
    bus.flushF = bus.exceptM;

    bus.div_busyE    = div_stall;
    bus.div_doneE    = div_done;
    bus.stall_cycles = stall_cnt;
  end

  // Divider sequencer; a done cycle blocked by dmem_busy is held at cnt==0.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (bus.exceptM) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.div_startE) begin
            state <= BUSY;
            cnt   <= LOAD;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (!bus.dmem_busy) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Saturating count of fetch-stall cycles.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stall_cnt <= '0;
    end else if (stall_f && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_interlock.sv
// Bench for pipe_interlock: two instances (default parameters, and a short
// divider / no W->D forwarding / 4-bit counter variant) share one stimulus.
// A rule-level reference model produces expected outputs into a queue that a
// separate monitor drains every cycle.
module tb_pipe_interlock;

  localparam int RW = 5;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  pipe_interlock_if #(.RW(RW), .CNT_W(32)) if0 ();
  pipe_interlock_if #(.RW(RW), .CNT_W(4))  if1 ();

  pipe_interlock #(.RW(RW), .DIV_CYCLES(32), .FWD_W2D(1), .CNT_W(32)) dut0 (
    .clk(clk), .resetn(resetn), .bus(if0.slave));
  pipe_interlock #(.RW(RW), .DIV_CYCLES(5), .FWD_W2D(0), .CNT_W(4)) dut1 (
    .clk(clk), .resetn(resetn), .bus(if1.slave));

  assign if1.rsD        = if0.rsD;
  assign if1.rtD        = if0.rtD;
  assign if1.branchD    = if0.branchD;
  assign if1.jumpD      = if0.jumpD;
  assign if1.rsE        = if0.rsE;
  assign if1.rtE        = if0.rtE;
  assign if1.writeregE  = if0.writeregE;
  assign if1.regwriteE  = if0.regwriteE;
  assign if1.memtoregE  = if0.memtoregE;
  assign if1.div_startE = if0.div_startE;
  assign if1.writeregM  = if0.writeregM;
  assign if1.regwriteM  = if0.regwriteM;
  assign if1.memtoregM  = if0.memtoregM;
  assign if1.exceptM    = if0.exceptM;
  assign if1.writeregW  = if0.writeregW;
  assign if1.regwriteW  = if0.regwriteW;
  assign if1.imem_busy  = if0.imem_busy;
  assign if1.dmem_busy  = if0.dmem_busy;

  typedef struct {
    logic [RW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic branchD, jumpD, regwriteE, memtoregE, div_startE;
    logic regwriteM, memtoregM, exceptM, regwriteW;
    logic imem_busy, dmem_busy, rst_n;
  } in_t;

  typedef struct {
    logic [1:0]  faD, fbD, faE, fbE;
    logic [4:0]  stall;   // {F,D,E,M,W}
    logic [4:0]  flush;   // {F,D,E,M,W}
    logic        busy, done;
    logic [31:0] sc;
  } out_t;

  typedef struct {
    out_t o0;
    out_t o1;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;

  // Model state: whether a divide is in flight, cycles left until its done
  // cycle (1 = done cycle), and the fetch-stall total.
  bit    act0, act1;
  int    left0, left1;
  longint sc0, sc1;

  function automatic bit hit(logic [RW-1:0] s, logic [RW-1:0] d, logic we);
    return (we == 1'b1) && (s != 0) && (s == d);
  endfunction

  function automatic out_t model_out(in_t i, bit w2d, bit act, int left, longint sc);
    out_t o;
    bit lw, br, ex, ds, sm, se, sd, sf;
    o.faD = hit(i.rsD, i.writeregE, i.regwriteE) ? 2'd1 : hit(i.rsD, i.writeregM, i.regwriteM) ? 2'd2 :
            (w2d && hit(i.rsD, i.writeregW, i.regwriteW)) ? 2'd3 : 2'd0;
    o.fbD = hit(i.rtD, i.writeregE, i.regwriteE) ? 2'd1 : hit(i.rtD, i.writeregM, i.regwriteM) ? 2'd2 :
            (w2d && hit(i.rtD, i.writeregW, i.regwriteW)) ? 2'd3 : 2'd0;
    o.faE = hit(i.rsE, i.writeregM, i.regwriteM) ? 2'd2 : hit(i.rsE, i.writeregW, i.regwriteW) ? 2'd1 : 2'd0;
    o.fbE = hit(i.rtE, i.writeregM, i.regwriteM) ? 2'd2 : hit(i.rtE, i.writeregW, i.regwriteW) ? 2'd1 : 2'd0;
    lw = i.memtoregE && (i.writeregE != 0) && (i.writeregE == i.rsD || i.writeregE == i.rtD);
    br = (i.branchD || i.jumpD) &&
         (hit(i.rsD, i.writeregE, i.regwriteE) || hit(i.rtD, i.writeregE, i.regwriteE) ||
          hit(i.rsD, i.writeregM, i.memtoregM) || hit(i.rtD, i.writeregM, i.memtoregM));
    ex = i.exceptM;
    ds = i.rst_n && !ex && ((!act && i.div_startE) || (act && left > 1));
    o.done = i.rst_n && !ex && act && left == 1 && !i.dmem_busy;
    o.busy = ds;
    sm = ex ? 1'b0 : i.dmem_busy;
    se = ex ? 1'b0 : (sm || ds);
    sd = ex ? 1'b0 : (se || lw || br);
    sf = ex ? 1'b0 : (sd || i.imem_busy);
    o.stall = {sf, sd, se, sm, 1'b0};
    o.flush = {ex, ex || (i.imem_busy && !sd), ex || ((lw || br) && !se), ex, i.dmem_busy && !ex};
    o.sc = sc[31:0];
    return o;
  endfunction

  task automatic model_step(input in_t i, input int div, input int cntw, input bit sf,
                            inout bit act, inout int left, inout longint sc);
    longint mx;
    mx = (64'd1 << cntw) - 1;
    if (!i.rst_n) begin
      act = 0; left = 0; sc = 0;
    end else begin
      if (i.exceptM) act = 0;
      else if (!act && i.div_startE) begin act = 1; left = div - 1; end
      else if (act) begin
        if (left > 1) left--;
        else if (!i.dmem_busy) act = 0;
      end
      if (sf && sc < mx) sc++;
    end
  endtask

  task automatic step(input in_t i);
    exp_t e;
    if0.rsD = i.rsD; if0.rtD = i.rtD; if0.branchD = i.branchD; if0.jumpD = i.jumpD;
    if0.rsE = i.rsE; if0.rtE = i.rtE; if0.writeregE = i.writeregE;
    if0.regwriteE = i.regwriteE; if0.memtoregE = i.memtoregE; if0.div_startE = i.div_startE;
    if0.writeregM = i.writeregM; if0.regwriteM = i.regwriteM; if0.memtoregM = i.memtoregM;
    if0.exceptM = i.exceptM; if0.writeregW = i.writeregW; if0.regwriteW = i.regwriteW;
    if0.imem_busy = i.imem_busy; if0.dmem_busy = i.dmem_busy; resetn = i.rst_n;
    e.o0 = model_out(i, 1'b1, act0, left0, sc0);
    e.o1 = model_out(i, 1'b0, act1, left1, sc1);
    sb.push_back(e);
    model_step(i, 32, 32, e.o0.stall[4], act0, left0, sc0);
    model_step(i, 5, 4, e.o1.stall[4], act1, left1, sc1);
    @(posedge clk);
    #1;
  endtask

  function automatic in_t idle();
    in_t i;
    i = '{default: '0};
    i.rst_n = 1'b1;
    return i;
  endfunction

  task automatic idle_n(input int n);
    for (int k = 0; k < n; k++) step(idle());
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
  endtask

  task automatic chk_out(input string tag, input out_t a, input out_t e);
    chk({tag, ".forwardaD"}, 32'(a.faD), 32'(e.faD));
    chk({tag, ".forwardbD"}, 32'(a.fbD), 32'(e.fbD));
    chk({tag, ".forwardaE"}, 32'(a.faE), 32'(e.faE));
    chk({tag, ".forwardbE"}, 32'(a.fbE), 32'(e.fbE));
    chk({tag, ".stall_FDEMW"}, 32'(a.stall), 32'(e.stall));
    chk({tag, ".flush_FDEMW"}, 32'(a.flush), 32'(e.flush));
    chk({tag, ".div_busyE"}, 32'(a.busy), 32'(e.busy));
    chk({tag, ".div_doneE"}, 32'(a.done), 32'(e.done));
    chk({tag, ".stall_cycles"}, a.sc, e.sc);
  endtask

  // Monitor: compare the presented outputs against the oldest expectation.
  initial begin
    exp_t e;
    out_t a0, a1;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a0.faD = if0.forwardaD; a0.fbD = if0.forwardbD; a0.faE = if0.forwardaE; a0.fbE = if0.forwardbE;
        a0.stall = {if0.stallF, if0.stallD, if0.stallE, if0.stallM, if0.stallW};
        a0.flush = {if0.flushF, if0.flushD, if0.flushE, if0.flushM, if0.flushW};
        a0.busy = if0.div_busyE; a0.done = if0.div_doneE; a0.sc = if0.stall_cycles;
        a1.faD = if1.forwardaD; a1.fbD = if1.forwardbD; a1.faE = if1.forwardaE; a1.fbE = if1.forwardbE;
        a1.stall = {if1.stallF, if1.stallD, if1.stallE, if1.stallM, if1.stallW};
        a1.flush = {if1.flushF, if1.flushD, if1.flushE, if1.flushM, if1.flushW};
        a1.busy = if1.div_busyE; a1.done = if1.div_doneE; a1.sc = {28'd0, if1.stall_cycles};
        chk_out("d0", a0, e.o0);
        chk_out("d1", a1, e.o1);
      end
    end
  end

  // Stimulus: directed scenarios followed by constrained-random traffic.
  initial begin
    in_t i;
    int  guard;
    act0 = 0; act1 = 0; left0 = 0; left1 = 0; sc0 = 0; sc1 = 0;
    i = idle();
    i.rst_n = 1'b0;
    if0.rsD = '0; if0.rtD = '0; if0.branchD = 0; if0.jumpD = 0; if0.rsE = '0; if0.rtE = '0;
    if0.writeregE = '0; if0.regwriteE = 0; if0.memtoregE = 0; if0.div_startE = 0;
    if0.writeregM = '0; if0.regwriteM = 0; if0.memtoregM = 0; if0.exceptM = 0;
    if0.writeregW = '0; if0.regwriteW = 0; if0.imem_busy = 0; if0.dmem_busy = 0;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step(i);                      // reset cycle: outputs from inputs, counters zero
    idle_n(10);

    // Full-length divide from idle.
    i = idle(); i.div_startE = 1; step(i);
    idle_n(40);

    // Load-use hazard, then the same with destination register 0.
    i = idle(); i.memtoregE = 1; i.writeregE = 8; i.rsD = 8; step(i);
    i.writeregE = 0; i.rsD = 0; step(i);
    i = idle(); i.memtoregE = 1; i.writeregE = 8; i.rtD = 8; i.branchD = 1; step(i);

    // Forwarding priority and the W->D path.
    i = idle(); i.rsD = 5; i.writeregE = 5; i.regwriteE = 1; i.writeregM = 5; i.regwriteM = 1; step(i);
    i = idle(); i.rsD = 5; i.rtD = 5; i.writeregW = 5; i.regwriteW = 1; step(i);
    i = idle(); i.rsE = 3; i.rtE = 3; i.writeregM = 3; i.regwriteM = 1; i.writeregW = 3; i.regwriteW = 1; step(i);
    i = idle(); i.jumpD = 1; i.rtD = 6; i.writeregM = 6; i.memtoregM = 1; step(i);

    // Exception in the middle of a divide.
    i = idle(); i.div_startE = 1; step(i);
    idle_n(19);
    i = idle(); i.exceptM = 1; i.dmem_busy = 1; i.imem_busy = 1; step(i);
    idle_n(15);

    // Data-memory busy over the done cycle of the long divide.
    i = idle(); i.div_startE = 1; step(i);
    idle_n(30);
    i = idle(); i.dmem_busy = 1; repeat (3) step(i);
    idle_n(5);

    // Long fetch stall saturates the narrow counter; reset clears it.
    i = idle(); i.imem_busy = 1; repeat (22) step(i);
    i = idle(); i.rst_n = 0; i.imem_busy = 1; step(i);
    idle_n(2);

    // Reset mid-divide must not produce a done.
    i = idle(); i.div_startE = 1; step(i);
    idle_n(5);
    i = idle(); i.rst_n = 0; i.div_startE = 1; step(i);
    idle_n(40);

    // Constrained-random traffic over a small register window.
    for (int n = 0; n < 3000; n++) begin
      i.rsD = RW'($urandom_range(0, 7));  i.rtD = RW'($urandom_range(0, 7));
      i.rsE = RW'($urandom_range(0, 7));  i.rtE = RW'($urandom_range(0, 7));
      i.writeregE = RW'($urandom_range(0, 7));
      i.writeregM = RW'($urandom_range(0, 7));
      i.writeregW = RW'($urandom_range(0, 7));
      i.branchD    = ($urandom_range(0, 5) == 0);
      i.jumpD      = ($urandom_range(0, 9) == 0);
      i.regwriteE  = $urandom_range(0, 1);
      i.memtoregE  = ($urandom_range(0, 3) == 0);
      i.div_startE = ($urandom_range(0, 9) == 0);
      i.regwriteM  = $urandom_range(0, 1);
      i.memtoregM  = ($urandom_range(0, 3) == 0);
      i.exceptM    = ($urandom_range(0, 39) == 0);
      i.regwriteW  = $urandom_range(0, 1);
      i.imem_busy  = ($urandom_range(0, 4) == 0);
      i.dmem_busy  = ($urandom_range(0, 5) == 0);
      i.rst_n      = ($urandom_range(0, 149) != 0);
      step(i);
    end
    idle_n(2);

    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (sb.size() > 0) begin
      total++;
      $display("FAIL drain actual=%0d pending expected=0 pending", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
